// File: rtl/charlieplex_pwm_source.sv
// charlieplex_pwm_source
//   PWM grey-level source feeding charlieplex_display. Holds a double-buffered
//   per-pixel brightness framebuffer and emits a binary pixelstate vector that
//   changes only once per PIXELCOUNT-cycle scan (one subframe). A PWM period is
//   (2^BRIGHTBITS-1) subframes; level k is lit for exactly k subframes of it.
//   The host writes the back buffer; a commit swaps it into the front buffer at
//   the next period boundary so a displayed period never mixes two images.
//
// Optional build macro: CHARLIEPLEX_READBACK_EN adds a registered read port on
//   the back buffer (rd_addr / rd_data). Without it no read logic exists.
//
// Ports:
//   pixelclock      in   pixel clock, shared with charlieplex_display
//   reset_n         in   asynchronous active-low reset
//   wr_en           in   back-buffer write strobe
//   wr_addr         in   pixel index to write (>= PIXELCOUNT ignored)
//   wr_data         in   brightness value
//   commit          in   request back->front swap at the next period end
//   commit_pending  out  swap requested but not yet performed
//   commit_done     out  one-cycle pulse after the swap edge
//   frame_start     out  one-cycle pulse at each PWM period start
//   pixelstate      out  on/off vector for charlieplex_display
//   rd_addr         in   (readback build only) back-buffer read index
//   rd_data         out  (readback build only) back[rd_addr], one cycle later

module charlieplex_pwm_source #(
    parameter int PIXELCOUNT = 12,
    parameter int BRIGHTBITS = 4,
    localparam int ADDRBITS  = $clog2(PIXELCOUNT)
) (
    input  logic                  pixelclock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDRBITS-1:0]   wr_addr,
    input  logic [BRIGHTBITS-1:0] wr_data,
    input  logic                  commit,
    output logic                  commit_pending,
    output logic                  commit_done,
    output logic                  frame_start,
`ifdef CHARLIEPLEX_READBACK_EN
    input  logic [ADDRBITS-1:0]   rd_addr,
    output logic [BRIGHTBITS-1:0] rd_data,
`endif
    output logic [PIXELCOUNT-1:0] pixelstate
);

    localparam logic [ADDRBITS-1:0]   SCAN_LAST = ADDRBITS'(PIXELCOUNT - 1);
    localparam logic [BRIGHTBITS-1:0] PWM_LAST  = BRIGHTBITS'((2 ** BRIGHTBITS) - 2);

    logic [BRIGHTBITS-1:0] front [PIXELCOUNT];
    logic [BRIGHTBITS-1:0] back  [PIXELCOUNT];

    logic [ADDRBITS-1:0]   scan_cnt;
    logic [BRIGHTBITS-1:0] pwm_cnt;

    logic                  scan_wrap;
    logic                  period_end;
    logic                  swap;
    logic                  wr_hit;
    logic [BRIGHTBITS-1:0] pwm_cnt_next;
    logic [BRIGHTBITS-1:0] front_next [PIXELCOUNT];
    logic [PIXELCOUNT-1:0] pix_next;

    always_comb begin
        scan_wrap  = (scan_cnt == SCAN_LAST);
        period_end = scan_wrap && (pwm_cnt == PWM_LAST);
        swap       = period_end && commit_pending;
        wr_hit     = wr_en && (32'(wr_addr) < PIXELCOUNT);

        pwm_cnt_next = pwm_cnt;
        if (scan_wrap) begin
            pwm_cnt_next = period_end ? '0 : pwm_cnt + BRIGHTBITS'(1);
        end

        // Compare against the post-swap image so the first subframe of a new
        // period already shows the newly committed frame.
        pix_next = '0;
        for (int unsigned i = 0; i < PIXELCOUNT; i++) begin
            front_next[i] = swap ? back[i] : front[i];
            pix_next[i]   = (front_next[i] > pwm_cnt_next);
        end
    end

    // Scan and PWM counters.
    always_ff @(posedge pixelclock or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt <= '0;
            pwm_cnt  <= '0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + ADDRBITS'(1);
            pwm_cnt  <= pwm_cnt_next;
        end
    end

    // Framebuffers. front samples back before this edge's write lands, so a
    // write on the swap edge only reaches the back buffer.
    always_ff @(posedge pixelclock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < PIXELCOUNT; i++) begin
                front[i] <= '0;
                back[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < PIXELCOUNT; i++) begin
                front[i] <= front_next[i];
            end
            if (wr_hit) begin
                back[wr_addr] <= wr_data;
            end
        end
    end

    // Commit handshake and frame markers. A commit arriving on the swap edge
    // is a fresh request for the following period.
    always_ff @(posedge pixelclock or negedge reset_n) begin
        if (!reset_n) begin
            commit_pending <= 1'b0;
            commit_done    <= 1'b0;
            frame_start    <= 1'b0;
        end else begin
            commit_pending <= swap ? commit : (commit_pending | commit);
            commit_done    <= swap;
            frame_start    <= period_end;
        end
    end

    // Output vector changes only at a scan wrap, stable for a whole scan.
    always_ff @(posedge pixelclock or negedge reset_n) begin
        if (!reset_n) begin
            pixelstate <= '0;
        end else if (scan_wrap) begin
            pixelstate <= pix_next;
        end
    end

`ifdef CHARLIEPLEX_READBACK_EN
    // Registered read of the back buffer; same-address write returns old data.
    always_ff @(posedge pixelclock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (32'(rd_addr) < PIXELCOUNT) begin
            rd_data <= back[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_charlieplex_pwm_source.sv
module tb_charlieplex_pwm_source;

    localparam int PC  = 12;
    localparam int BB  = 4;
    localparam int SUB = (2 ** BB) - 1;
    localparam int PER = PC * SUB;

    logic          pixelclock = 1'b0;
    logic          reset_n;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [BB-1:0] wr_data;
    logic          commit;
    logic          commit_pending;
    logic          commit_done;
    logic          frame_start;
    logic [PC-1:0] pixelstate;

    charlieplex_pwm_source #(.PIXELCOUNT(PC), .BRIGHTBITS(BB)) dut (
        .pixelclock     (pixelclock),
        .reset_n        (reset_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit         (commit),
        .commit_pending (commit_pending),
        .commit_done    (commit_done),
        .frame_start    (frame_start),
        .pixelstate     (pixelstate)
    );

    always #5 pixelclock = ~pixelclock;

    int checks = 0;
    int errors = 0;

    // Reference state: n counts active edges since reset release; the subframe
    // index and period boundaries are derived arithmetically from n.
    int            n = 0;
    logic [BB-1:0] m_front [PC];
    logic [BB-1:0] m_back  [PC];
    logic          m_pending = 1'b0;
    logic [PC-1:0] exp_pix = '0;
    logic          exp_frame = 1'b0;
    logic          exp_done = 1'b0;
    int            done_q[$];
    int            done_cnt = 0;
    int            fs_first = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < PC; i++) begin
            m_front[i] = '0;
            m_back[i]  = '0;
        end
        m_pending = 1'b0;
        exp_pix   = '0;
        exp_frame = 1'b0;
        exp_done  = 1'b0;
        done_q.delete();
    endtask

    task automatic model_edge();
        logic boundary, wrap, swap;
        n++;
        boundary = (n % PER == 0);
        wrap     = (n % PC == 0);
        swap     = boundary && m_pending;
        if (swap) begin
            for (int i = 0; i < PC; i++) m_front[i] = m_back[i];
        end
        // Scoreboard: each accepted request expects a done pulse at the
        // first period boundary strictly after this edge.
        if (commit && (swap || !m_pending)) done_q.push_back((n / PER + 1) * PER);
        m_pending = swap ? commit : (m_pending | commit);
        if (wr_en && int'(wr_addr) < PC) m_back[wr_addr] = wr_data;
        if (wrap) begin
            for (int i = 0; i < PC; i++) exp_pix[i] = (int'(m_front[i]) > ((n / PC) % SUB));
        end
        exp_frame = boundary;
        exp_done  = swap;
    endtask

    task automatic check_outputs();
        int expn;
        chk("pixelstate", pixelstate, exp_pix);
        chk("frame_start", frame_start, exp_frame);
        chk("commit_pending", commit_pending, m_pending);
        chk("commit_done", commit_done, exp_done);
        if (commit_done === 1'b1) begin
            done_cnt++;
            expn = (done_q.size() > 0) ? done_q.pop_front() : -1;
            chk("commit_done_edge", n, expn);
        end
        if (frame_start === 1'b1 && fs_first < 0) fs_first = n;
    endtask

    task automatic tick();
        @(posedge pixelclock);
        if (reset_n) model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run_until(input int target);
        int guard = 0;
        while (n < target && guard < 5000) begin
            tick();
            guard++;
        end
        chk("run_until_reached", n, target);
    endtask

    initial begin
        int c0, c1, c2, d0;

        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        commit  = 1'b0;
        model_reset();

        // Reset state, then idle run with an empty framebuffer.
        tick();
        tick();
        reset_n = 1'b1;
        run_until(400);
        chk("first_frame_start", fs_first, PER);

        // Load a three-pixel image and commit it.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'd15; tick();
        wr_addr = 4'd1; wr_data = 4'd0; tick();
        wr_addr = 4'd2; wr_data = 4'd5; tick();
        wr_en = 1'b0; commit = 1'b1; tick();
        commit = 1'b0;
        run_until(540);
        chk("img_done_count", done_cnt, 1);
        c0 = 0; c1 = 0; c2 = 0;
        for (int k = 0; k < PER; k++) begin
            if (n % PC == 0) begin
                c0 += int'(pixelstate[0]);
                c1 += int'(pixelstate[1]);
                c2 += int'(pixelstate[2]);
            end
            tick();
        end
        chk("pix0_on_subframes", c0, 15);
        chk("pix1_on_subframes", c1, 0);
        chk("pix2_on_subframes", c2, 5);

        // Repeated commits within one period yield a single swap.
        run_until(730);
        d0 = done_cnt;
        for (int r = 0; r < 3; r++) begin
            commit = 1'b1; tick();
            commit = 1'b0;
            for (int w = 0; w < 9; w++) tick();
        end
        run_until(905);
        chk("multi_commit_done_pulses", done_cnt - d0, 1);

        // Write on the swap edge goes to back only.
        commit = 1'b1; tick();
        commit = 1'b0;
        run_until(1079);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 4'd9; tick();
        wr_en = 1'b0;
        chk("swap_edge_write_pix3_old", pixelstate[3], 1'b0);
        commit = 1'b1; tick();
        commit = 1'b0;
        run_until(1260);
        chk("second_commit_pix3_new", pixelstate[3], 1'b1);

        // Out-of-range write is dropped; committed image is unchanged.
        wr_en = 1'b1; wr_addr = 4'd12; wr_data = 4'd15; tick();
        wr_en = 1'b0; commit = 1'b1; tick();
        commit = 1'b0;
        run_until(1440);
        chk("oob_write_image", pixelstate, 12'h00D);

        // Asynchronous reset with a commit pending.
        commit = 1'b1; tick();
        commit = 1'b0;
        run_until(1500);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_pixelstate", pixelstate, '0);
        chk("async_rst_pending", commit_pending, 1'b0);
        chk("async_rst_done", commit_done, 1'b0);
        chk("async_rst_frame_start", frame_start, 1'b0);
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;
        d0 = done_cnt;
        run_until(PER + 5);
        chk("no_done_after_reset", done_cnt - d0, 0);
        chk("scoreboard_empty", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
